// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: width default, group and
// opcode encodings, and compare result codes.
package alu_pkg;

   localparam int DATA_WIDTH_DEF = 16;

   // ALU_FUN[3:2] group select
   typedef enum logic [1:0] {
      GRP_ARITH = 2'b00,
      GRP_LOGIC = 2'b01,
      GRP_CMP   = 2'b10,
      GRP_SHIFT = 2'b11
   } alu_grp_e;

   // Full 4-bit opcodes
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_NOP  = 4'b1000;
   localparam logic [3:0] OP_CEQ  = 4'b1001;
   localparam logic [3:0] OP_CGT  = 4'b1010;
   localparam logic [3:0] OP_CLT  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;
   localparam logic [3:0] OP_SLA  = 4'b1101;
   localparam logic [3:0] OP_SRB  = 4'b1110;
   localparam logic [3:0] OP_SLB  = 4'b1111;

   // Compare result codes
   localparam int CMP_EQ = 1;
   localparam int CMP_GT = 2;
   localparam int CMP_LT = 3;

endpackage

// File: rtl/alu_fun_decoder.sv
// Decodes the group field of the function code into one-hot group enables.
module alu_fun_decoder
   import alu_pkg::*;
(
   input  logic [1:0] grp,
   output logic       arith_en,
   output logic       logic_en,
   output logic       cmp_en,
   output logic       shift_en
);

   // One-hot enable per functional group
   always_comb begin
      arith_en = 1'b0;
      logic_en = 1'b0;
      cmp_en   = 1'b0;
      shift_en = 1'b0;
      case (alu_grp_e'(grp))
         GRP_ARITH: arith_en = 1'b1;
         GRP_LOGIC: logic_en = 1'b1;
         GRP_CMP:   cmp_en   = 1'b1;
         GRP_SHIFT: shift_en = 1'b1;
         default:   arith_en = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_top_unit.sv
// Registered 16-bit ALU with four functional groups, each with its own
// result bus and valid flag. One cycle latency, one result per cycle.
module alu_top_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [3:0]            ALU_FUN,
   output logic [DATA_WIDTH-1:0] Arith_OUT,
   output logic                  Carry_OUT,
   output logic [DATA_WIDTH-1:0] Logic_OUT,
   output logic [DATA_WIDTH-1:0] CMP_OUT,
   output logic [DATA_WIDTH-1:0] Shift_OUT,
   output logic                  Arith_Flag,
   output logic                  Logic_Flag,
   output logic                  CMP_Flag,
   output logic                  Shift_Flag
);

   // Division with a defined zero result for a zero divisor
   function automatic logic [DATA_WIDTH-1:0] safe_div(
      input logic [DATA_WIDTH-1:0] num,
      input logic [DATA_WIDTH-1:0] den
   );
      if (den == '0)
         return '0;
      return num / den;
   endfunction

   logic                  arith_en_p0, logic_en_p0, cmp_en_p0, shift_en_p0;
   logic [DATA_WIDTH:0]   ext_sum_p0;
   logic [DATA_WIDTH:0]   ext_diff_p0;
   logic [DATA_WIDTH-1:0] arith_res_p0;
   logic                  carry_res_p0;
   logic [DATA_WIDTH-1:0] logic_res_p0;
   logic [DATA_WIDTH-1:0] cmp_res_p0;
   logic [DATA_WIDTH-1:0] shift_res_p0;

   alu_fun_decoder u_dec (
      .grp      (ALU_FUN[3:2]),
      .arith_en (arith_en_p0),
      .logic_en (logic_en_p0),
      .cmp_en   (cmp_en_p0),
      .shift_en (shift_en_p0)
   );

   // p0: combinational group datapaths
   assign ext_sum_p0  = {1'b0, A} + {1'b0, B};
   assign ext_diff_p0 = {1'b0, A} - {1'b0, B};

   // Arithmetic group; the extra MSB of add/sub is carry/borrow
   always_comb begin
      arith_res_p0 = '0;
      carry_res_p0 = 1'b0;
      case (ALU_FUN)
         OP_ADD: begin
            arith_res_p0 = ext_sum_p0[DATA_WIDTH-1:0];
            carry_res_p0 = ext_sum_p0[DATA_WIDTH];
         end
         OP_SUB: begin
            arith_res_p0 = ext_diff_p0[DATA_WIDTH-1:0];
            carry_res_p0 = ext_diff_p0[DATA_WIDTH];
         end
         OP_MUL:  arith_res_p0 = DATA_WIDTH'(A * B);
         OP_DIV:  arith_res_p0 = safe_div(A, B);
         default: arith_res_p0 = '0;
      endcase
   end

   // Logic group
   always_comb begin
      logic_res_p0 = '0;
      case (ALU_FUN)
         OP_AND:  logic_res_p0 = A & B;
         OP_OR:   logic_res_p0 = A | B;
         OP_NAND: logic_res_p0 = ~(A & B);
         OP_NOR:  logic_res_p0 = ~(A | B);
         default: logic_res_p0 = '0;
      endcase
   end

   // Compare group, unsigned; code is 0 when the tested relation fails
   always_comb begin
      cmp_res_p0 = '0;
      case (ALU_FUN)
         OP_NOP:  cmp_res_p0 = '0;
         OP_CEQ:  cmp_res_p0 = (A == B) ? DATA_WIDTH'(CMP_EQ) : '0;
         OP_CGT:  cmp_res_p0 = (A > B)  ? DATA_WIDTH'(CMP_GT) : '0;
         OP_CLT:  cmp_res_p0 = (A < B)  ? DATA_WIDTH'(CMP_LT) : '0;
         default: cmp_res_p0 = '0;
      endcase
   end

   // Shift group, logical with zero fill
   always_comb begin
      shift_res_p0 = '0;
      case (ALU_FUN)
         OP_SRA:  shift_res_p0 = A >> 1;
         OP_SLA:  shift_res_p0 = A << 1;
         OP_SRB:  shift_res_p0 = B >> 1;
         OP_SLB:  shift_res_p0 = B << 1;
         default: shift_res_p0 = '0;
      endcase
   end

   // p1: output registers; unselected groups load zero
   always_ff @(posedge CLK) begin
      if (RST) begin
         Arith_OUT  <= '0;
         Carry_OUT  <= 1'b0;
         Logic_OUT  <= '0;
         CMP_OUT    <= '0;
         Shift_OUT  <= '0;
         Arith_Flag <= 1'b0;
         Logic_Flag <= 1'b0;
         CMP_Flag   <= 1'b0;
         Shift_Flag <= 1'b0;
      end else begin
         Arith_OUT  <= arith_en_p0 ? arith_res_p0 : '0;
         Carry_OUT  <= arith_en_p0 & carry_res_p0;
         Logic_OUT  <= logic_en_p0 ? logic_res_p0 : '0;
         CMP_OUT    <= cmp_en_p0   ? cmp_res_p0   : '0;
         Shift_OUT  <= shift_en_p0 ? shift_res_p0 : '0;
         Arith_Flag <= arith_en_p0;
         Logic_Flag <= logic_en_p0;
         CMP_Flag   <= cmp_en_p0;
         Shift_Flag <= shift_en_p0;
      end
   end

endmodule

// File: tb/tb_alu_top_unit.sv
// Directed bench for alu_top_unit with hand-computed expected values.
module tb_alu_top_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] A, B;
   logic [3:0]  ALU_FUN;
   logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
   logic        Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

   int total = 0;
   int bad   = 0;

   alu_top_unit dut (
      .CLK        (CLK),
      .RST        (RST),
      .A          (A),
      .B          (B),
      .ALU_FUN    (ALU_FUN),
      .Arith_OUT  (Arith_OUT),
      .Carry_OUT  (Carry_OUT),
      .Logic_OUT  (Logic_OUT),
      .CMP_OUT    (CMP_OUT),
      .Shift_OUT  (Shift_OUT),
      .Arith_Flag (Arith_Flag),
      .Logic_Flag (Logic_Flag),
      .CMP_Flag   (CMP_Flag),
      .Shift_Flag (Shift_Flag)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the expected set
   task automatic chk_all(input string tag, input logic [15:0] ea, input logic ec,
                          input logic [15:0] el, input logic [15:0] ecm,
                          input logic [15:0] es, input logic [3:0] ef);
      chk({tag, ".arith"}, {16'h0, Arith_OUT}, {16'h0, ea});
      chk({tag, ".carry"}, {31'h0, Carry_OUT}, {31'h0, ec});
      chk({tag, ".logic"}, {16'h0, Logic_OUT}, {16'h0, el});
      chk({tag, ".cmp"},   {16'h0, CMP_OUT},   {16'h0, ecm});
      chk({tag, ".shift"}, {16'h0, Shift_OUT}, {16'h0, es});
      chk({tag, ".flags"}, {28'h0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}, {28'h0, ef});
   endtask

   // Drive operands at the falling edge, then step past the next rising edge
   task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
      @(negedge CLK);
      A = a; B = b; ALU_FUN = f;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; A = 16'h1234; B = 16'h0001; ALU_FUN = 4'b0000;
      repeat (2) @(posedge CLK);
      #1;
      chk_all("reset", 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b0000);

      // Release reset; nothing is valid until the next edge
      @(negedge CLK);
      RST = 1'b0; A = 16'd10; B = 16'd5; ALU_FUN = 4'b0000;
      chk("pre_edge.flags", {28'h0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}, 32'h0);
      @(posedge CLK); #1;
      chk_all("add", 16'd15, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'd10, 16'd5, 4'b0001); chk_all("sub", 16'd5,  1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'd10, 16'd5, 4'b0010); chk_all("mul", 16'd50, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'd10, 16'd5, 4'b0011); chk_all("div", 16'd2,  1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);

      // Carry, borrow, wrap and divide by zero
      apply(16'h8000, 16'h8000, 4'b0000); chk_all("add_carry",  16'h0000, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'd5, 16'd10, 4'b0001);      chk_all("sub_borrow", 16'hFFFB, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'd5, 16'd0, 4'b0011);       chk_all("div_zero",   16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
      apply(16'h0100, 16'h0101, 4'b0010); chk_all("mul_wrap",   16'h0100, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);

      // Logic group
      apply(16'hF0F0, 16'h89F0, 4'b0100); chk_all("and",  16'h0, 1'b0, 16'h80F0, 16'h0, 16'h0, 4'b0100);
      apply(16'hF0F0, 16'h89F0, 4'b0101); chk_all("or",   16'h0, 1'b0, 16'hF9F0, 16'h0, 16'h0, 4'b0100);
      apply(16'hF0F0, 16'h89F0, 4'b0110); chk_all("nand", 16'h0, 1'b0, 16'h7F0F, 16'h0, 16'h0, 4'b0100);
      apply(16'hF0F0, 16'h89F0, 4'b0111); chk_all("nor",  16'h0, 1'b0, 16'h060F, 16'h0, 16'h0, 4'b0100);

      // Compare group
      apply(16'd10, 16'd5, 4'b1000);   chk_all("cmp_nop",   16'h0, 1'b0, 16'h0, 16'd0, 16'h0, 4'b0010);
      apply(16'd10, 16'd5, 4'b1001);   chk_all("cmp_eq_no", 16'h0, 1'b0, 16'h0, 16'd0, 16'h0, 4'b0010);
      apply(16'd10, 16'd5, 4'b1010);   chk_all("cmp_gt",    16'h0, 1'b0, 16'h0, 16'd2, 16'h0, 4'b0010);
      apply(16'd10, 16'd5, 4'b1011);   chk_all("cmp_lt_no", 16'h0, 1'b0, 16'h0, 16'd0, 16'h0, 4'b0010);
      apply(16'd55, 16'd55, 4'b1001);  chk_all("cmp_eq",    16'h0, 1'b0, 16'h0, 16'd1, 16'h0, 4'b0010);
      apply(16'd10, 16'd117, 4'b1011); chk_all("cmp_lt",    16'h0, 1'b0, 16'h0, 16'd3, 16'h0, 4'b0010);
      apply(16'd10, 16'd117, 4'b1010); chk_all("cmp_gt_no", 16'h0, 1'b0, 16'h0, 16'd0, 16'h0, 4'b0010);

      // Shift group
      apply(16'h00FF, 16'h00FF, 4'b1100); chk_all("shr_a", 16'h0, 1'b0, 16'h0, 16'h0, 16'h007F, 4'b0001);
      apply(16'h00FF, 16'h00FF, 4'b1101); chk_all("shl_a", 16'h0, 1'b0, 16'h0, 16'h0, 16'h01FE, 4'b0001);
      apply(16'h00FF, 16'h00FF, 4'b1110); chk_all("shr_b", 16'h0, 1'b0, 16'h0, 16'h0, 16'h007F, 4'b0001);
      apply(16'h00FF, 16'h00FF, 4'b1111); chk_all("shl_b", 16'h0, 1'b0, 16'h0, 16'h0, 16'h01FE, 4'b0001);
      apply(16'h8001, 16'h1234, 4'b1101); chk_all("shl_msb", 16'h0, 1'b0, 16'h0, 16'h0, 16'h0002, 4'b0001);
      apply(16'h1234, 16'h8001, 4'b1110); chk_all("shr_b2", 16'h0, 1'b0, 16'h0, 16'h0, 16'h4000, 4'b0001);

      // Output holds until the edge, then takes the value present at the edge
      @(negedge CLK);
      A = 16'd3; B = 16'd4; ALU_FUN = 4'b0000;
      chk("hold.shift", {16'h0, Shift_OUT}, 32'h4000);
      #2 ALU_FUN = 4'b0010;
      @(posedge CLK); #1;
      chk_all("late_fun", 16'd12, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);

      // Reset mid-stream wins over the pending operation, then operation resumes
      apply(16'hFFFF, 16'h0001, 4'b0000); chk_all("b2b_add", 16'h0000, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);
      @(negedge CLK);
      RST = 1'b1; A = 16'hAAAA; B = 16'h5555; ALU_FUN = 4'b0101;
      @(posedge CLK); #1;
      chk_all("mid_reset", 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b0000);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk_all("resume_or", 16'h0, 1'b0, 16'hFFFF, 16'h0, 16'h0, 4'b0100);
      apply(16'd7, 16'd9, 4'b1011); chk_all("b2b_lt",  16'h0, 1'b0, 16'h0, 16'd3, 16'h0, 4'b0010);
      apply(16'd7, 16'd9, 4'b0001); chk_all("b2b_sub", 16'hFFFE, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
